mem_stage_pipe: RTL and testbench
=================================

// Module: mem_stage_pipe
// PURPOSE
//  Parametrised pipeline memory stage with an internal data memory, a variable-latency load path
//  and a registered MEM/WB output. Sits between EX and WB. Generalises the fixed 24-bit memory
//  stage: widths and depth are configurable, load latency is configurable, with valid/ready stall and flush.
// PARAMETERS
//  DATA_W  24   data / ALU result width
//  REG_W   4    register index width
//  DEPTH   256  data memory words; ADDR_W = $clog2(DEPTH)
//  RD_LAT  2    load latency in cycles, legal 1..8
// PORTS
//  clk             in   1       clock, rising edge
//  reset           in   1       asynchronous, active-low reset
//  flush           in   1       sync kill of in-flight op and output valid
//  in_valid        in   1       EX presents an op this cycle
//  in_ready        out  1       stage can accept (= state==IDLE && !flush)
//  memWe           in   1       store: mem[result] <= dataToWrite
//  memRe           in   1       load from mem[result]
//  writeRegFromAlu in   1       writeback value = result, not memory
//  regWe           in   1       register write enable, passed through
//  dataToWrite     in   DATA_W  store data
//  result          in   DATA_W  ALU result / effective address
//  regToWrite      in   REG_W   destination register, passed through
//  out_valid       out  1       MEM/WB output valid, 1-cycle pulse per op
//  regWeOut        out  1       registered regWe (forced 0 on addr error)
//  dataToWriteOut  out  DATA_W  writeback value
//  regToWriteOut   out  REG_W   registered regToWrite
//  addr_err        out  1       registered: mem op with result >= DEPTH
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE, latency counter 0, all outputs 0. in_ready is 1 once reset
//    releases. Memory contents are not reset.
//  - Accept = in_valid && in_ready. Classification, in priority order:
//    1. writeRegFromAlu=1: ALU op. memRe is ignored; memWe is still honoured.
//    2. memWe=1: store. memRe is ignored.
//    3. memRe=1: load.
//    4. none of the above: NOP-through.
//  - Address = result[ADDR_W-1:0]; it is out of range if result >= DEPTH.
//  - Store: the write commits on the accepting edge. Out-of-range: no write, addr_err=1.
//  - ALU/store/NOP: out_valid=1 on the edge after accept (latency 1). dataToWriteOut=result for ALU,
//    0 otherwise.
//  - Load with RD_LAT=1: same as ALU timing; dataToWriteOut=mem[addr].
//  - Load with RD_LAT>1: go IDLE->LOAD_WAIT and load counter with RD_LAT-1. in_ready=0 while in
//    LOAD_WAIT. Decrement the counter each cycle. At 0, register mem[addr], out_valid=1, return to
//    IDLE. out_valid rises RD_LAT cycles after the accepting edge.
//  - Out-of-range load: the same latency applies; data=0, addr_err=1, regWeOut=0.
//  - Read sees all prior writes: a store accepted at cycle N is visible to a load accepted at N+1.
//  - The output register holds values until the next completion. out_valid is 0 in every cycle
//    without a completion.
//  - Throughput: 1 op/cycle for non-load ops; 1 load per RD_LAT cycles.
//  - flush=1 (sync):
//    * forces in_ready=0, so no accept that cycle;
//    * aborts LOAD_WAIT and returns to IDLE;
//    * clears out_valid, regWeOut and addr_err on the next edge.
//    Stores already committed remain in memory.
//  - Reset asserted mid-load: immediate abort; outputs 0; no out_valid for that load afterwards.
//  - Counter width = $clog2(RD_LAT)+1. RD_LAT outside 1..8 is an elaboration error ($error).
// TESTING
//  1. ALU op: result=24'h00ABCD, regToWrite=3, regWe=1, writeRegFromAlu=1 -> next edge out_valid=1,
//     dataToWriteOut=24'h00ABCD, regToWriteOut=3, regWeOut=1.
//  2. Store then load, RD_LAT=2: store 24'h123456 @5, then load @5 into r7 ->
//     - load accepted the cycle after the store;
//     - in_ready=0 for 1 cycle;
//     - out_valid 2 cycles after accept with data 24'h123456 and regToWriteOut=7.
//  3. Out of range, DEPTH=256: store to result=300 -> addr_err=1 and mem unchanged; then load
//     result=300 -> data 0, regWeOut=0, addr_err=1.
//  4. Flush mid-load, RD_LAT=4: flush 2 cycles after accept -> out_valid never rises for that load,
//     in_ready=1 the cycle after flush, and the next ALU op completes normally.
//  5. Reset mid-load: reset=0 one cycle after load accept -> all outputs 0 immediately; after release
//     in_ready=1 and no stale out_valid.
//  6. Back-to-back: 4 consecutive ALU ops with in_valid held 1 -> 4 consecutive out_valid pulses with
//     in-order data; then priority check memWe=memRe=1 -> treated as store, latency 1.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// Pipeline memory stage between EX and WB: internal data memory, variable-latency
// load path with valid/ready stall, sync flush and a registered MEM/WB output.
module mem_stage_pipe #(
    parameter int DATA_W = 24,
    parameter int REG_W  = 4,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              memWe,
    input  logic              memRe,
    input  logic              writeRegFromAlu,
    input  logic              regWe,
    input  logic [DATA_W-1:0] dataToWrite,
    input  logic [DATA_W-1:0] result,
    input  logic [REG_W-1:0]  regToWrite,
    output logic              out_valid,
    output logic              regWeOut,
    output logic [DATA_W-1:0] dataToWriteOut,
    output logic [REG_W-1:0]  regToWriteOut,
    output logic              addr_err
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(RD_LAT) + 1;
    localparam logic [DATA_W:0]  DEPTH_X  = (DATA_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);
    localparam bit MULTI = (RD_LAT > 1);

    generate
        if (RD_LAT < 1 || RD_LAT > 8) begin : gBadLat
            $error("mem_stage_pipe: RD_LAT must be in 1..8");
        end
    endgenerate

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t            state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic              loadDone;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] addr;
    logic              inRange, accept, isAlu, isLoad, memOp, opErr, startWait;

    // Load captured at accept and completed from LOAD_WAIT
    logic [ADDR_W-1:0] pendAddr;
    logic [REG_W-1:0]  pendReg;
    logic              pendRegWe, pendErr;

    assign addr      = result[ADDR_W-1:0];
    assign inRange   = ({1'b0, result} < DEPTH_X);
    assign in_ready  = (state == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    // Priority: ALU beats store beats load; an ALU op still honours memWe
    assign isAlu     = writeRegFromAlu;
    assign isLoad    = !writeRegFromAlu && !memWe && memRe;
    assign memOp     = memWe || isLoad;
    assign opErr     = memOp && !inRange;
    assign startWait = accept && isLoad && MULTI;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        loadDone  = 1'b0;
        case (state)
            IDLE: begin
                if (startWait) begin
                    stateNext = LOAD_WAIT;
                    cntNext   = CNT_INIT;
                end
            end
            LOAD_WAIT: begin
                if (flush) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cnt == CNT_W'(1)) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                    loadDone  = 1'b1;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && memWe && inRange) mem[addr] <= dataToWrite;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            out_valid      <= 1'b0;
            regWeOut       <= 1'b0;
            dataToWriteOut <= '0;
            regToWriteOut  <= '0;
            addr_err       <= 1'b0;
            pendAddr       <= '0;
            pendReg        <= '0;
            pendRegWe      <= 1'b0;
            pendErr        <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            out_valid <= 1'b0;
            if (flush) begin
                regWeOut <= 1'b0;
                addr_err <= 1'b0;
            end else if (loadDone) begin
                out_valid      <= 1'b1;
                dataToWriteOut <= pendErr ? '0 : mem[pendAddr];
                regToWriteOut  <= pendReg;
                regWeOut       <= pendRegWe && !pendErr;
                addr_err       <= pendErr;
            end else if (accept && !startWait) begin
                out_valid      <= 1'b1;
                dataToWriteOut <= isAlu ? result : ((isLoad && inRange) ? mem[addr] : '0);
                regToWriteOut  <= regToWrite;
                regWeOut       <= regWe && !opErr;
                addr_err       <= opErr;
            end
            if (startWait) begin
                pendAddr  <= addr;
                pendReg   <= regToWrite;
                pendRegWe <= regWe;
                pendErr   <= opErr;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: directed scenarios plus randomized traffic against a
// transaction-level model, on two instances with load latency 2 and 4.
module tb_mem_stage_pipe;
    logic clk = 1'b0;
    logic reset;
    logic        flush [2];
    logic        inValid [2];
    logic        memWe [2];
    logic        memRe [2];
    logic        wrAlu [2];
    logic        regWe [2];
    logic [23:0] dataW [2];
    logic [23:0] res [2];
    logic [3:0]  regTo [2];
    logic        inReady [2];
    logic        outValid [2];
    logic        regWeO [2];
    logic [23:0] dataO [2];
    logic [3:0]  regToO [2];
    logic        addrErr [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.DATA_W(24), .REG_W(4), .DEPTH(256), .RD_LAT(2)) u0 (
        .clk(clk), .reset(reset), .flush(flush[0]), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .memWe(memWe[0]), .memRe(memRe[0]), .writeRegFromAlu(wrAlu[0]), .regWe(regWe[0]),
        .dataToWrite(dataW[0]), .result(res[0]), .regToWrite(regTo[0]), .out_valid(outValid[0]),
        .regWeOut(regWeO[0]), .dataToWriteOut(dataO[0]), .regToWriteOut(regToO[0]),
        .addr_err(addrErr[0]));

    mem_stage_pipe #(.DATA_W(24), .REG_W(4), .DEPTH(256), .RD_LAT(4)) u1 (
        .clk(clk), .reset(reset), .flush(flush[1]), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .memWe(memWe[1]), .memRe(memRe[1]), .writeRegFromAlu(wrAlu[1]), .regWe(regWe[1]),
        .dataToWrite(dataW[1]), .result(res[1]), .regToWrite(regTo[1]), .out_valid(outValid[1]),
        .regWeOut(regWeO[1]), .dataToWriteOut(dataO[1]), .regToWriteOut(regToO[1]),
        .addr_err(addrErr[1]));

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input int d, input logic v, input logic we, input logic re, input logic alu,
                       input logic rwe, input logic [23:0] dw, input logic [23:0] r,
                       input logic [3:0] rt);
        inValid[d] = v; memWe[d] = we; memRe[d] = re; wrAlu[d] = alu;
        regWe[d] = rwe; dataW[d] = dw; res[d] = r; regTo[d] = rt;
    endtask

    task automatic idleAll();
        for (int d = 0; d < 2; d++) begin
            flush[d] = 1'b0;
            drv(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 4'h0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idleAll();
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({outValid[d], regWeO[d], addrErr[d], dataO[d], regToO[d]} !== 31'h0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got=%b/%b/%b/%h/%h want all zero", d,
                         outValid[d], regWeO[d], addrErr[d], dataO[d], regToO[d]);
            end
        end
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (inReady[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready dut=%0d got=%b want=1", d, inReady[d]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_alu();
        drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 24'h00ABCD, 4'd3);
        step();
        idleAll();
        checks++;
        if ({outValid[0], dataO[0], regToO[0], regWeO[0], addrErr[0]} !== {1'b1, 24'h00ABCD, 4'd3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL alu_op got v=%b d=%h r=%0d we=%b e=%b want v=1 d=00abcd r=3 we=1 e=0",
                     outValid[0], dataO[0], regToO[0], regWeO[0], addrErr[0]);
        end
        step();
        checks++;
        if (outValid[0] !== 1'b0 || dataO[0] !== 24'h00ABCD) begin
            failures++;
            $display("FAIL alu_hold got v=%b d=%h want v=0 d=00abcd", outValid[0], dataO[0]);
        end
    endtask

    task automatic test_store_load();
        drv(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h123456, 24'd5, 4'd0);
        step();
        drv(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, 24'd5, 4'd7);
        #1;
        checks++;
        if (inReady[0] !== 1'b1 || outValid[0] !== 1'b1 || dataO[0] !== 24'h0) begin
            failures++;
            $display("FAIL store_done got rdy=%b v=%b d=%h want rdy=1 v=1 d=0", inReady[0], outValid[0], dataO[0]);
        end
        step();
        idleAll();
        checks++;
        if (inReady[0] !== 1'b0 || outValid[0] !== 1'b0) begin
            failures++;
            $display("FAIL load_wait got rdy=%b v=%b want rdy=0 v=0", inReady[0], outValid[0]);
        end
        step();
        checks++;
        if ({inReady[0], outValid[0], dataO[0], regToO[0], regWeO[0]} !== {1'b1, 1'b1, 24'h123456, 4'd7, 1'b1}) begin
            failures++;
            $display("FAIL load_data got rdy=%b v=%b d=%h r=%0d we=%b want rdy=1 v=1 d=123456 r=7 we=1",
                     inReady[0], outValid[0], dataO[0], regToO[0], regWeO[0]);
        end
        step();
        checks++;
        if (outValid[0] !== 1'b0) begin
            failures++;
            $display("FAIL load_pulse got v=%b want=0", outValid[0]);
        end
    endtask

    task automatic test_range();
        drv(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0000AA, 24'd44, 4'd0);
        step();
        drv(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'd300, 4'd2);
        step();
        idleAll();
        checks++;
        if ({outValid[0], addrErr[0], regWeO[0]} !== 3'b110) begin
            failures++;
            $display("FAIL oor_store got v=%b e=%b we=%b want v=1 e=1 we=0", outValid[0], addrErr[0], regWeO[0]);
        end
        drv(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, 24'd300, 4'd4);
        step();
        idleAll();
        step();
        checks++;
        if ({outValid[0], dataO[0], regWeO[0], addrErr[0]} !== {1'b1, 24'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL oor_load got v=%b d=%h we=%b e=%b want v=1 d=0 we=0 e=1",
                     outValid[0], dataO[0], regWeO[0], addrErr[0]);
        end
        drv(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, 24'd44, 4'd4);
        step();
        idleAll();
        step();
        checks++;
        if ({outValid[0], dataO[0], regWeO[0], addrErr[0]} !== {1'b1, 24'h0000AA, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL oor_mem_intact got v=%b d=%h we=%b e=%b want v=1 d=0000aa we=1 e=0",
                     outValid[0], dataO[0], regWeO[0], addrErr[0]);
        end
    endtask

    task automatic test_flush();
        int seen;
        drv(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, 24'd9, 4'd6);
        step();
        idleAll();
        step();
        flush[1] = 1'b1;
        #1;
        checks++;
        if (inReady[1] !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready_low got=%b want=0", inReady[1]);
        end
        step();
        flush[1] = 1'b0;
        #1;
        checks++;
        if ({inReady[1], outValid[1], regWeO[1], addrErr[1]} !== 4'b1000) begin
            failures++;
            $display("FAIL flush_after got rdy=%b v=%b we=%b e=%b want 1/0/0/0",
                     inReady[1], outValid[1], regWeO[1], addrErr[1]);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (outValid[1] !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_no_valid got pulses=%0d want=0", seen);
        end
        drv(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 24'h0055AA, 4'd9);
        step();
        idleAll();
        checks++;
        if ({outValid[1], dataO[1], regToO[1], regWeO[1]} !== {1'b1, 24'h0055AA, 4'd9, 1'b1}) begin
            failures++;
            $display("FAIL flush_next_alu got v=%b d=%h r=%0d we=%b want v=1 d=0055aa r=9 we=1",
                     outValid[1], dataO[1], regToO[1], regWeO[1]);
        end
    endtask

    task automatic test_reset_mid_load();
        int seen;
        drv(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 24'h000777, 4'd5);
        step();
        drv(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, 24'd3, 4'd8);
        step();
        idleAll();
        reset = 1'b0;
        #1;
        checks++;
        if ({outValid[1], regWeO[1], addrErr[1], dataO[1], regToO[1]} !== 31'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs got v=%b we=%b e=%b d=%h r=%h want all zero",
                     outValid[1], regWeO[1], addrErr[1], dataO[1], regToO[1]);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (inReady[1] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_ready got=%b want=1", inReady[1]);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (outValid[1] !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_stale got pulses=%0d want=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] vals [4];
        for (int i = 0; i < 4; i++) vals[i] = 24'($urandom);
        for (int i = 0; i < 4; i++) begin
            drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0, vals[i], 4'(i + 1));
            step();
            checks++;
            if ({outValid[0], dataO[0], regToO[0]} !== {1'b1, vals[i], 4'(i + 1)}) begin
                failures++;
                $display("FAIL b2b_%0d got v=%b d=%h r=%0d want v=1 d=%h r=%0d", i,
                         outValid[0], dataO[0], regToO[0], vals[i], i + 1);
            end
        end
        drv(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h00BEEF, 24'd8, 4'd2);
        step();
        idleAll();
        checks++;
        if ({inReady[0], outValid[0], dataO[0], regWeO[0]} !== {1'b1, 1'b1, 24'h0, 1'b1}) begin
            failures++;
            $display("FAIL prio_store got rdy=%b v=%b d=%h we=%b want rdy=1 v=1 d=0 we=1",
                     inReady[0], outValid[0], dataO[0], regWeO[0]);
        end
        drv(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0, 24'd8, 4'd2);
        step();
        idleAll();
        step();
        checks++;
        if ({outValid[0], dataO[0]} !== {1'b1, 24'h00BEEF}) begin
            failures++;
            $display("FAIL prio_store_mem got v=%b d=%h want v=1 d=00beef", outValid[0], dataO[0]);
        end
    endtask

    typedef struct {
        int          done;
        logic [23:0] data;
        logic [3:0]  rt;
        logic        rwe;
        logic        err;
    } exp_t;

    task automatic test_random(input int d, input int n);
        exp_t        q[$];
        exp_t        x;
        logic [23:0] mdl [256];
        int          nextFree, inits, L;
        bit          ready, seen, v, we, re, alu, rwe, isLoad, err;
        logic [23:0] dw, r, hData;
        logic [3:0]  rt, hRt;
        logic        hRwe, hErr;
        int          kind;
        nextFree = 0; inits = 0; seen = 0;
        hData = '0; hRt = '0; hRwe = 1'b0; hErr = 1'b0;
        for (int e = 0; e < n + 8; e++) begin
            ready = (e >= nextFree);
            v = 0; we = 0; re = 0; alu = 0;
            rwe = 1'($urandom); dw = 24'($urandom); rt = 4'($urandom); r = 24'($urandom_range(15, 0));
            if (e < n) begin
                if (inits < 16 && ready) begin
                    v = 1; we = 1; r = 24'(inits); inits++;
                end else if (inits >= 16) begin
                    v = ($urandom_range(3, 0) != 0);
                    kind = int'($urandom_range(3, 0));
                    if ($urandom_range(5, 0) == 0) r = 24'(256 + $urandom_range(999, 0));
                    case (kind)
                        0: begin alu = 1; we = ($urandom_range(7, 0) == 0); re = 1'($urandom);
                                 if (!we) r = 24'($urandom); end
                        1: begin we = 1; re = 1'($urandom); end
                        2: re = 1;
                        default: ;
                    endcase
                end
            end
            drv(d, v, we, re, alu, rwe, dw, r, rt);
            #1;
            checks++;
            if (inReady[d] !== ready) begin
                failures++;
                $display("FAIL rnd_ready dut=%0d cyc=%0d got=%b want=%b", d, e, inReady[d], ready);
            end
            if (v && ready) begin
                isLoad = !alu && !we && re;
                err = (we || isLoad) && (r >= 24'd256);
                L = isLoad ? lat(d) : 1;
                x.done = e + L - 1;
                x.data = alu ? r : ((isLoad && !err) ? mdl[r[7:0]] : 24'h0);
                x.rt = rt;
                x.rwe = rwe && !err;
                x.err = err;
                if (we && !err) mdl[r[7:0]] = dw;
                q.push_back(x);
                nextFree = e + L;
            end
            step();
            if (q.size() > 0 && q[0].done == e) begin
                x = q.pop_front();
                hData = x.data; hRt = x.rt; hRwe = x.rwe; hErr = x.err;
                seen = 1;
                checks++;
                if (outValid[d] !== 1'b1) begin
                    failures++;
                    $display("FAIL rnd_valid dut=%0d cyc=%0d got=%b want=1", d, e, outValid[d]);
                end
            end else begin
                checks++;
                if (outValid[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_idle dut=%0d cyc=%0d got=%b want=0", d, e, outValid[d]);
                end
            end
            if (seen) begin
                checks++;
                if ({dataO[d], regToO[d], regWeO[d], addrErr[d]} !== {hData, hRt, hRwe, hErr}) begin
                    failures++;
                    $display("FAIL rnd_out dut=%0d cyc=%0d got d=%h r=%0d we=%b e=%b want d=%h r=%0d we=%b e=%b",
                             d, e, dataO[d], regToO[d], regWeO[d], addrErr[d], hData, hRt, hRwe, hErr);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rnd_drain dut=%0d pending=%0d want=0", d, q.size());
        end
        idleAll();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idleAll();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_store_load();
        test_range();
        test_flush();
        test_back_to_back();
        test_random(0, 400);
        test_random(1, 400);
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
